// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_tx among num_req requesters and
// aborts any character whose transmitter fails to report done in time.
module uart_tx_arbiter #(
    parameter int num_req        = 4,
    parameter int data_bits      = 8,
    parameter int timeout_cycles = 40000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic [num_req-1:0]           req,
    input  logic [num_req*data_bits-1:0] req_data,
    output logic [num_req-1:0]           ack,
    output logic [$clog2(num_req)-1:0]   grant_id,
    output logic                         busy,
    output logic                         timeout_err,
    output logic                         tx_start,
    output logic [data_bits-1:0]         tx_data_out,
    input  logic                         tx_active,
    input  logic                         done_tx
);

    localparam int id_w = $clog2(num_req);
    localparam int wd_w = 20;
    localparam logic [wd_w-1:0] wd_last = wd_w'(timeout_cycles - 1);
    localparam logic [id_w-1:0] id_max  = id_w'(num_req - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_ACT,
        WAIT_DONE
    } state_t;

    state_t                 state;
    logic [id_w-1:0]        last_grant;
    logic [wd_w-1:0]        watchdog;

    logic                   pick_valid;
    logic [id_w-1:0]        pick_id;
    logic [data_bits-1:0]   pick_data;
    logic [num_req-1:0]     grant_onehot;

    // Search upward from last_grant+1 with wrap; the nearest set bit is
    // assigned last, so it wins.
    always_comb begin
        // NOTE: every comb output gets a default first so no path infers a latch.
        pick_valid = 1'b0;
        pick_id    = '0;
        for (int l = 0; l < num_req; l++) begin
            if (last_grant == id_w'(l)) begin
                for (int k = num_req; k >= 1; k--) begin
                    if (req[(l + k) % num_req]) begin
                        pick_valid = 1'b1;
                        pick_id    = id_w'((l + k) % num_req);
                    end
                end
            end
        end
    end

    always_comb begin
        pick_data = '0;
        for (int i = 0; i < num_req; i++) begin
            if (pick_id == id_w'(i)) begin
                pick_data = req_data[i*data_bits +: data_bits];
            end
        end
    end

    always_comb begin
        grant_onehot = '0;
        for (int i = 0; i < num_req; i++) begin
            grant_onehot[i] = (grant_id == id_w'(i));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            tx_start    <= 1'b0;
            tx_data_out <= '0;
            ack         <= '0;
            grant_id    <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            watchdog    <= '0;
            last_grant  <= id_max;
        end else begin
            // NOTE: state is updated with non-blocking assignments only, so
            // every branch below sees the values from before this edge.
            tx_start    <= 1'b0;
            ack         <= '0;
            timeout_err <= 1'b0;

            case (state)
                IDLE: begin
                    if (enable && pick_valid) begin
                        grant_id    <= pick_id;
                        tx_data_out <= pick_data;
                        tx_start    <= 1'b1;
                        busy        <= 1'b1;
                        state       <= LOAD;
                    end
                end

                LOAD: begin
                    watchdog <= '0;
                    state    <= WAIT_ACT;
                end

                WAIT_ACT, WAIT_DONE: begin
                    // done_tx in WAIT_ACT covers a transmitter too fast to
                    // show tx_active before finishing.
                    if (done_tx) begin
                        ack        <= grant_onehot;
                        last_grant <= grant_id;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end else if (watchdog == wd_last) begin
                        timeout_err <= 1'b1;
                        last_grant  <= grant_id;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        watchdog <= watchdog + 1'b1;
                        if (state == WAIT_ACT && tx_active) begin
                            state <= WAIT_DONE;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter num_req, default 4, number of requesters sharing one uart_tx; range 2-8.
REQ-002 Parameter data_bits, default 8, character width; SHALL match the attached uart_tx.
REQ-003 Parameter timeout_cycles, default 40000, maximum clk cycles from tx_start to done_tx before abort; range 1 to 2^20-1.
REQ-004 clk  input  1  sole clock, all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 enable  input  1  1 = new grants allowed; 0 = no new grant, in-flight character completes.
REQ-007 req  input  num_req  per-requester request, level; held high until matching ack.
REQ-008 req_data  input  num_req*data_bits  packed characters; requester i occupies bits [i*data_bits +: data_bits], stable while req[i] high.
REQ-009 ack  output  num_req  one-cycle pulse on completion of requester i's character.
REQ-010 grant_id  output  $clog2(num_req)  index of current/last granted requester.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 timeout_err  output  1  one-cycle pulse on watchdog abort.
REQ-013 tx_start  output  1  to uart_tx start; one-cycle pulse.
REQ-014 tx_data_out  output  data_bits  to uart_tx tx_data_in; registered, held from grant until return to IDLE.
REQ-015 tx_active  input  1  from uart_tx; high while frame on line.
REQ-016 done_tx  input  1  from uart_tx; one-cycle pulse at end of stop bit(s).

Function
REQ-017 FSM states SHALL be IDLE, LOAD, WAIT_ACT, WAIT_DONE; all outputs registered.
REQ-018 IDLE: if enable=1 and req!=0, grant the first set req bit searching upward from (last_grant+1) mod num_req with wrap; latch req_data slice into tx_data_out, grant index into grant_id; go LOAD.
REQ-019 LOAD: tx_start=1 for exactly this one cycle; watchdog counter cleared; go WAIT_ACT.
REQ-020 WAIT_ACT: on tx_active=1 go WAIT_DONE; on done_tx=1 (fast transmitter) treat as WAIT_DONE completion directly.
REQ-021 WAIT_DONE: on done_tx=1 pulse ack[grant_id] next cycle, set last_grant=grant_id, go IDLE.
REQ-022 Latency: req rising in IDLE at edge k -> tx_start high in cycle k+1; ack high in cycle after done_tx sampled.
REQ-023 Watchdog counts every cycle in WAIT_ACT/WAIT_DONE; at count = timeout_cycles without done_tx: timeout_err pulse one cycle, no ack, last_grant=grant_id, go IDLE.
REQ-024 done_tx or tx_active seen in IDLE or LOAD SHALL be ignored.
REQ-025 req[i] dropping after grant SHALL NOT abort; character completes and ack[i] still pulses.
REQ-026 enable going low mid-character SHALL NOT affect the in-flight character.
REQ-027 At most one ack bit high per cycle; ack and timeout_err never high together.
REQ-028 Back-to-back: after ack cycle FSM is in IDLE and may grant on that same edge, so minimum gap from done_tx to next tx_start is 2 cycles.
REQ-029 Fairness: with all req held high, grants SHALL cycle 0,1,...,num_req-1,0 with no requester served twice before each other active requester once.

Reset
REQ-030 rst=1 SHALL immediately force state IDLE, tx_start=0, tx_data_out=0, ack=0, grant_id=0, busy=0, timeout_err=0, watchdog=0, last_grant=num_req-1 (requester 0 wins first).
REQ-031 rst mid-character SHALL discard the character with no ack; external uart_tx shares rst.

Verification
REQ-032 Single: req=4'b0100, data[2]=8'hA5 -> tx_start one cycle, tx_data_out=8'hA5, grant_id=2; done_tx -> ack=4'b0100 one cycle, busy falls.
REQ-033 Round-robin: req=4'b1111 held, each done_tx answered -> grant_id sequence 0,1,2,3,0; ack one-hot each time.
REQ-034 Timeout: timeout_cycles=16, tx_active never rises -> timeout_err at cycle 16 after LOAD, no ack, next grant goes to next requester.
REQ-035 Enable: enable=0 with req=4'b0001 -> no tx_start for 100 cycles; enable=1 -> tx_start next cycle; enable=0 mid-frame -> ack still issued.
REQ-036 Reset mid-frame: rst pulse in WAIT_DONE -> all outputs 0 asynchronously, no ack; after release req=4'b1000 -> grant_id=3.
REQ-037 Drop: req[1] deasserted after tx_start -> done_tx still yields ack=4'b0010.
